// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - state_t      : controller FSM states
//   - OP_*         : opcodes recognised in S_DECODE
//   - FN_*         : R-type funct codes
//   - ALU_*        : ALU operation codes, ALU_CODE_W bits, zero-extended at the top level
//   - is_wait_state: states in which the memory-wait timeout counter runs
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int ALU_CODE_W = 3;
  typedef logic [ALU_CODE_W-1:0] alu_code_t;

  localparam alu_code_t ALU_ADD = 3'd0;
  localparam alu_code_t ALU_SUB = 3'd1;
  localparam alu_code_t ALU_AND = 3'd2;
  localparam alu_code_t ALU_OR  = 3'd3;
  localparam alu_code_t ALU_SLT = 3'd4;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the data_path.
//   master : controller side (receives opcode/funct/zero/mem_ready, drives controls and flags)
//   slave  : data_path side
// Parameter ALU_SEL_W sets the width of ALUSelector.
interface mips_mc_ctrl_if #(
  parameter int ALU_SEL_W = 3
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 MemaReg;
  logic                 enWrSram;
  logic [ALU_SEL_W-1:0] ALUSelector;
  logic                 enWriteMemory;
  logic                 ftePC;
  logic                 enablePC;
  logic                 fteALU;
  logic                 regDst;
  logic                 instr_done;
  logic                 err_illegal;
  logic                 err_timeout;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output MemaReg, enWrSram, ALUSelector, enWriteMemory, ftePC, enablePC,
           fteALU, regDst, instr_done, err_illegal, err_timeout
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  MemaReg, enWrSram, ALUSelector, enWriteMemory, ftePC, enablePC,
           fteALU, regDst, instr_done, err_illegal, err_timeout
  );
endinterface

// File: rtl/mips_alu_dec.sv
// Combinational R-type funct -> ALU operation decode.
//   funct   : instr[5:0]
//   alu_sel : ALU operation code (ALU_ADD when funct is unknown)
//   valid   : 1 when funct is a supported operation
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output alu_code_t  alu_sel,
  output logic       valid
);

  always_comb begin
    alu_sel = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_sel = ALU_ADD;
      FN_SUB:  alu_sel = ALU_SUB;
      FN_AND:  alu_sel = ALU_AND;
      FN_OR:   alu_sel = ALU_OR;
      FN_SLT:  alu_sel = ALU_SLT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle decode FSM driving the MIPS data_path control set.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; all outputs read 0 while it is high
//   bus : mips_mc_ctrl_if.master -- opcode/funct/zero/mem_ready in,
//         MemaReg/enWrSram/ALUSelector/enWriteMemory/ftePC/enablePC/fteALU/regDst,
//         instr_done pulse and sticky err_illegal/err_timeout out
// Parameters: ALU_SEL_W (>=3), MEM_TIMEOUT (max memory wait), TMO_W (2**TMO_W > MEM_TIMEOUT).
// Optional feature: define MIPS_MC_CTRL_BRANCH_EN to execute beq (opcode 0x04);
// otherwise beq is reported as illegal.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALU_SEL_W   = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  if (ALU_SEL_W < ALU_CODE_W) begin : g_chk_alu_w
    $error("mips_mc_ctrl: ALU_SEL_W must be at least 3");
  end
  if ((64'd1 << TMO_W) <= 64'(MEM_TIMEOUT)) begin : g_chk_tmo_w
    $error("mips_mc_ctrl: TMO_W too narrow for MEM_TIMEOUT");
  end

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       fn_q, fn_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_timeout_q, err_timeout_d;

  alu_code_t dec_sel;
  logic      dec_valid;
  logic      tmo_hit;
  logic      op_illegal;

  logic      mema_reg, en_wr_sram, en_write_mem, fte_pc, enable_pc, fte_alu, reg_dst, instr_done;
  alu_code_t alu_sel;
  logic [ALU_SEL_W-1:0] alu_sel_ext;

  // R-type decode works on the funct latched in S_DECODE, so the data_path
  // may change the instruction inputs once decode has passed.
  mips_alu_dec u_alu_dec (
    .funct   (fn_q),
    .alu_sel (dec_sel),
    .valid   (dec_valid)
  );

  // mem_ready arriving in the limit cycle wins over the abort.
  assign tmo_hit = (tmo_q == TMO_LIMIT) && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      tmo_q         <= '0;
      op_q          <= '0;
      fn_q          <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      op_q          <= op_d;
      fn_q          <= fn_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    fn_d          = fn_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    op_illegal    = 1'b0;
    mema_reg      = 1'b0;
    en_wr_sram    = 1'b0;
    en_write_mem  = 1'b0;
    fte_pc        = 1'b0;
    enable_pc     = 1'b0;
    fte_alu       = 1'b0;
    reg_dst       = 1'b0;
    instr_done    = 1'b0;
    alu_sel       = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          enable_pc = 1'b1;
          state_d   = S_DECODE;
        end else if (tmo_hit) begin
          err_timeout_d = 1'b1;
        end
      end

      S_DECODE: begin
        op_d = bus.opcode;
        fn_d = bus.funct;
        case (bus.opcode)
          OP_RTYPE:              state_d = S_EXEC_R;
          OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC_I;
`ifdef MIPS_MC_CTRL_BRANCH_EN
          OP_BEQ:                state_d = S_BRANCH;
`else
          OP_BEQ:                op_illegal = 1'b1;
`endif
          default:               op_illegal = 1'b1;
        endcase
        if (op_illegal) begin
          err_illegal_d = 1'b1;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
      end

      S_EXEC_R: begin
        if (dec_valid) begin
          alu_sel = dec_sel;
          state_d = S_WB_R;
        end else begin
          err_illegal_d = 1'b1;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
      end

      S_WB_R: begin
        alu_sel    = dec_sel;
        reg_dst    = 1'b1;
        en_wr_sram = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_EXEC_I: begin
        fte_alu = 1'b1;
        case (op_q)
          OP_ADDI: state_d = S_WB_I;
          OP_LW:   state_d = S_MEM_RD;
          default: state_d = S_MEM_WR;  // only sw reaches here otherwise
        endcase
      end

      S_WB_I: begin
        fte_alu    = 1'b1;
        en_wr_sram = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_RD: begin
        fte_alu = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_WB_MEM;
        end else if (tmo_hit) begin
          err_timeout_d = 1'b1;
          state_d       = S_FETCH;
        end
      end

      S_WB_MEM: begin
        mema_reg   = 1'b1;
        en_wr_sram = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        fte_alu = 1'b1;
        if (bus.mem_ready) begin
          en_write_mem = 1'b1;
          instr_done   = 1'b1;
          state_d      = S_FETCH;
        end else if (tmo_hit) begin
          // abort cycle: the write strobe drops here
          err_timeout_d = 1'b1;
          state_d       = S_FETCH;
        end else begin
          en_write_mem = 1'b1;
        end
      end

`ifdef MIPS_MC_CTRL_BRANCH_EN
      S_BRANCH: begin
        alu_sel = ALU_SUB;
        if (bus.zero) begin
          fte_pc    = 1'b1;
          enable_pc = 1'b1;
        end
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif

      default: state_d = S_FETCH;
    endcase

    // The counter only accumulates while parked in a wait state; any move
    // (including the timeout abort back into S_FETCH) restarts it.
    if ((state_d != state_q) || tmo_hit || !is_wait_state(state_q)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (rst) begin
      mema_reg     = 1'b0;
      en_wr_sram   = 1'b0;
      en_write_mem = 1'b0;
      fte_pc       = 1'b0;
      enable_pc    = 1'b0;
      fte_alu      = 1'b0;
      reg_dst      = 1'b0;
      instr_done   = 1'b0;
      alu_sel      = ALU_ADD;
    end
  end

`ifndef MIPS_MC_CTRL_BRANCH_EN
  logic unused_zero;
  assign unused_zero = bus.zero;
`endif

  genvar gi;
  for (gi = 0; gi < ALU_SEL_W; gi++) begin : g_alu_ext
    if (gi < ALU_CODE_W) begin : g_lo
      assign alu_sel_ext[gi] = alu_sel[gi];
    end else begin : g_hi
      assign alu_sel_ext[gi] = 1'b0;
    end
  end

  assign bus.MemaReg       = mema_reg;
  assign bus.enWrSram      = en_wr_sram;
  assign bus.ALUSelector   = alu_sel_ext;
  assign bus.enWriteMemory = en_write_mem;
  assign bus.ftePC         = fte_pc;
  assign bus.enablePC      = enable_pc;
  assign bus.fteALU        = fte_alu;
  assign bus.regDst        = reg_dst;
  assign bus.instr_done    = instr_done;
  assign bus.err_illegal   = err_illegal_q && !rst;
  assign bus.err_timeout   = err_timeout_q && !rst;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle control unit for the 32-bit MIPS data_path.
- Replaces hand-driven control vectors with a decode FSM.
- Inputs: opcode/funct of the current instruction, the ALU zero flag and a memory-ready handshake.
- Outputs: the data_path control set (MemaReg, enWrSram, ALUSelector, enWriteMemory, ftePC, enablePC, fteALU, regDst), generated per state.
- Parametrised ALU-select width and a memory-wait timeout counter.

Parameters:
ALU_SEL_W, 3, width of ALUSelector; must be ≥3.
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready in any memory state before abort.
TMO_W, 4, width of the timeout counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26]; sampled in S_DECODE
funct  input  6  instr[5:0]; sampled in S_DECODE
zero  input  1  ALU zero flag
mem_ready  input  1  memory access complete this cycle
MemaReg  output  1  1: write-back data from memory; 0: from ALU
enWrSram  output  1  register-file write enable
ALUSelector  output  ALU_SEL_W  ALU operation
enWriteMemory  output  1  data-memory write enable
ftePC  output  1  PC source: 0 = PC+4, 1 = branch target
enablePC  output  1  PC load enable
fteALU  output  1  ALU operand B: 0 = register, 1 = sign-extended immediate
regDst  output  1  destination register: 1 = rd, 0 = rt
instr_done  output  1  one-cycle pulse when an instruction retires
err_illegal  output  1  sticky; unknown opcode or funct
err_timeout  output  1  sticky; memory wait exceeded MEM_TIMEOUT

Behaviour:
- Reset (rst=1 at a clk edge):
  - State := S_FETCH, timeout counter := 0, latched opcode/funct := 0, both error flags := 0.
  - Every output is forced to 0 while rst is high.
  - Reset mid-instruction aborts it; no write enable is asserted in the reset cycle.
- States and outputs (any output not listed is 0):
  - S_FETCH:
    - Wait for mem_ready.
    - On mem_ready: enablePC=1, ftePC=0 (combinational, same cycle); go to S_DECODE.
  - S_DECODE:
    - Latch opcode/funct.
    - Dispatch on opcode: 0x00 → S_EXEC_R; 0x08 (addi), 0x23 (lw), 0x2B (sw) → S_EXEC_I; 0x04 (beq) → S_BRANCH (only with the optional feature).
    - Any other opcode: set err_illegal, pulse instr_done, go to S_FETCH.
  - S_EXEC_R:
    - fteALU=0; ALUSelector from funct: 0x20→ADD, 0x22→SUB, 0x24→AND, 0x25→OR, 0x2A→SLT.
    - Go to S_WB_R.
    - Unknown funct: err_illegal, instr_done pulse, go to S_FETCH, no write.
  - S_WB_R: ALUSelector held, regDst=1, MemaReg=0, enWrSram=1, instr_done=1; go to S_FETCH.
  - S_EXEC_I:
    - fteALU=1, ALUSelector=ADD.
    - Next state: addi → S_WB_I, lw → S_MEM_RD, sw → S_MEM_WR.
  - S_WB_I: fteALU=1, ALU=ADD, regDst=0, MemaReg=0, enWrSram=1, instr_done=1; go to S_FETCH.
  - S_MEM_RD:
    - fteALU=1, ALU=ADD; wait for mem_ready.
    - On mem_ready: go to S_WB_MEM.
  - S_WB_MEM: MemaReg=1, regDst=0, enWrSram=1, instr_done=1; go to S_FETCH.
  - S_MEM_WR:
    - fteALU=1, ALU=ADD, enWriteMemory=1 held until mem_ready.
    - On mem_ready: instr_done=1; go to S_FETCH.
- Timeout counter:
  - Runs in S_FETCH, S_MEM_RD and S_MEM_WR; clears on every state change.
  - If it reaches MEM_TIMEOUT with mem_ready low: set err_timeout, go to S_FETCH, no write enables that cycle.
  - mem_ready in the same cycle the count reaches MEM_TIMEOUT: mem_ready wins; no error.
- Latency: R-type, addi and sw with zero-wait memory = 4 cycles (FETCH, DECODE, EXEC, WB/MEM); lw = 5 cycles.
- ALUSelector is zero-extended to ALU_SEL_W.
- Error flags clear only on rst.

Optional Feature:
- Macro: MIPS_MC_CTRL_BRANCH_EN.
- Defined:
  - Opcode 0x04 goes to S_BRANCH: fteALU=0, ALU=SUB.
  - If zero=1: ftePC=1, enablePC=1 in that cycle.
  - Then instr_done=1; go to S_FETCH.
- Undefined: 0x04 is treated as illegal (err_illegal set).

Decomposition:
- Package mips_pkg holds:
  - state enum;
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ;
  - funct constants;
  - ALU codes ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4.
- One sub-module, mips_alu_dec: combinational funct→ALUSelector decode with a valid flag.

Test Plan:
- rst high for 2 cycles, then low with mem_ready=1, opcode=0x00, funct=0x22 → S_WB_R at cycle 4: ALUSelector=1, regDst=1, enWrSram=1, instr_done=1.
- lw (0x23) with mem_ready low for 3 cycles in S_MEM_RD → S_WB_MEM 4 cycles after entry: MemaReg=1, enWrSram=1; no error.
- sw (0x2B), mem_ready held low → enWriteMemory=1 for 15 cycles, then err_timeout=1, return to S_FETCH, enWriteMemory=0.
- opcode=0x3F → err_illegal=1 after S_DECODE; no enWrSram or enWriteMemory pulse; next fetch proceeds.
- With MIPS_MC_CTRL_BRANCH_EN: beq with zero=1 → ftePC=1, enablePC=1 for one cycle. Repeat with zero=0 → enablePC stays 0.
- Assert rst during S_WB_MEM → enWrSram=0 that cycle; state returns to S_FETCH; both flags 0.
